// File: rtl/yin_frame_sequencer.sv
// Frame sequencer for a YIN pitch core: buffers a sliding sample window, snapshots
// it every HOP samples, restarts the core, and holds the resulting lag for a consumer.
module yin_frame_sequencer #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned WINDOW_SIZE_BITS = 8,
    parameter int unsigned MAX_TAU          = 40,
    parameter int unsigned HOP              = 64,
    parameter int unsigned TIMEOUT          = 65535,
    localparam int unsigned FRAME_LEN       = 2**WINDOW_SIZE_BITS + MAX_TAU
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            s_valid,
    input  logic [DATA_WIDTH-1:0]           s_data,
    output logic                            s_ready,
    input  logic                            enable,
    output logic [DATA_WIDTH*FRAME_LEN-1:0] frame_data,
    output logic                            core_rst,
    input  logic                            core_ready,
    input  logic [7:0]                      core_tau,
    output logic                            tau_valid,
    output logic [7:0]                      tau,
    input  logic                            tau_ack,
    output logic                            timeout,
    output logic                            busy,
    output logic [15:0]                     overrun_count
);

    localparam int unsigned BUF_W  = DATA_WIDTH * FRAME_LEN;
    localparam int unsigned FILL_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned HOP_W  = $clog2(HOP + 1);
    localparam int unsigned RUN_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [BUF_W-1:0]    live_buf;
    logic [FILL_W-1:0]   fill_count;
    logic [HOP_W-1:0]    hop_count;
    logic [RUN_W-1:0]    run_cnt;
    logic                ovr_armed;
    logic                accept;
    logic                fill_full;
    logic                hop_full;
    logic                run_expired;

    // Samples are never back-pressured outside reset.
    assign s_ready     = reset;
    assign accept      = s_valid & s_ready;
    assign fill_full   = (fill_count == FILL_W'(FRAME_LEN));
    assign hop_full    = (hop_count == HOP_W'(HOP));
    assign run_expired = (run_cnt == RUN_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable && fill_full && hop_full) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = ARM;
            ARM:    state_d = RUN;
            RUN: begin
                if (core_ready || run_expired) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (tau_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they align with state_q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            tau_valid <= 1'b0;
        end else begin
            core_rst  <= (state_d == IDLE) || (state_d == LAUNCH) || (state_d == ARM);
            busy      <= (state_d != IDLE);
            tau_valid <= (state_d == REPORT);
        end
    end

    // Live window: oldest sample in the low slot, newest written at the top.
    always_ff @(posedge clk) begin
        if (accept) begin
            live_buf <= {s_data, live_buf[BUF_W-1:DATA_WIDTH]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_count <= '0;
            hop_count  <= '0;
        end else begin
            if (accept && !fill_full) begin
                fill_count <= fill_count + FILL_W'(1);
            end
            if (state_q == LAUNCH) begin
                hop_count <= accept ? HOP_W'(1) : '0;
            end else if (accept && !hop_full) begin
                hop_count <= hop_count + HOP_W'(1);
            end
        end
    end

    // Snapshot taken from the pre-edge buffer, so a same-cycle accept is excluded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_data <= '0;
        end else if (state_q == LAUNCH) begin
            frame_data <= live_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (state_q == RUN) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end else begin
            run_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tau     <= '0;
            timeout <= 1'b0;
        end else if (state_q == RUN) begin
            if (core_ready) begin
                tau     <= core_tau;
                timeout <= 1'b0;
            end else if (run_expired) begin
                tau     <= '0;
                timeout <= 1'b1;
            end
        end
    end

    // One overrun per launch: the armed flag is consumed by the first dropped hop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovr_armed     <= 1'b0;
            overrun_count <= '0;
        end else if (state_q == LAUNCH) begin
            ovr_armed <= 1'b1;
        end else if ((state_q == ARM || state_q == RUN || state_q == REPORT) &&
                     accept && hop_full && ovr_armed) begin
            ovr_armed <= 1'b0;
            if (overrun_count != 16'hFFFF) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/yin_frame_sequencer.md
YIN_FRAME_SEQUENCER -- requirements
Module: yin_frame_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, bits per sample; WINDOW_SIZE_BITS, default 8, log2 window length; MAX_TAU, default 40, lag count; HOP, default 64, samples between launches, 1 <= HOP <= FRAME_LEN; TIMEOUT, default 65535, max core run cycles.
REQ-002 FRAME_LEN SHALL be a derived localparam equal to 2**WINDOW_SIZE_BITS + MAX_TAU.
REQ-003 Ports SHALL be: clk  in  1  clock; reset  in  1  reset, synchronous, active-low.
REQ-004 Stream input ports SHALL be: s_valid  in  1  sample offered; s_data  in  DATA_WIDTH  sample; s_ready  out  1  sample accepted when s_valid & s_ready.
REQ-005 Control port SHALL be: enable  in  1  launches permitted.
REQ-006 Core-side ports SHALL be: frame_data  out  DATA_WIDTH*FRAME_LEN  frame snapshot to core; core_rst  out  1  active-high core restart; core_ready  in  1  core result valid; core_tau  in  8  core lag.
REQ-007 Result ports SHALL be: tau_valid  out  1  result pending; tau  out  8  latched lag; tau_ack  in  1  consumer accepts; timeout  out  1  current result produced by timeout; busy  out  1  state != IDLE; overrun_count  out  16  dropped hops.

Function
REQ-008 s_ready SHALL be 1 in every cycle in which reset is high; samples are never back-pressured.
REQ-009 The live buffer SHALL hold FRAME_LEN samples: index 0 oldest, index FRAME_LEN-1 newest at bits [k*DATA_WIDTH +: DATA_WIDTH]; each accept shifts toward index 0 and writes s_data at FRAME_LEN-1.
REQ-010 fill_count SHALL increment per accept, saturating at FRAME_LEN; hop_count SHALL increment per accept, saturating at HOP.
REQ-011 FSM states SHALL be IDLE, LAUNCH, ARM, RUN, REPORT.
REQ-012 IDLE -> LAUNCH when enable=1, fill_count==FRAME_LEN and hop_count==HOP, evaluated on registered values.
REQ-013 In LAUNCH (one cycle), frame_data SHALL load the live buffer as registered at the start of that cycle, excluding any same-cycle accept; hop_count SHALL become 0, or 1 if a sample is accepted that cycle; next state ARM.
REQ-014 core_rst SHALL be 1 in IDLE, LAUNCH and ARM, and 0 in RUN and REPORT; ARM lasts exactly one cycle, then RUN.
REQ-015 In RUN, core_ready=1 SHALL latch tau<=core_tau, timeout<=0, go REPORT; if core_ready stays 0 for TIMEOUT RUN cycles, tau<=0, timeout<=1, go REPORT.
REQ-016 In REPORT, tau_valid SHALL be 1; tau_ack=1 -> tau_valid 0 next cycle, state IDLE; tau and timeout hold until the next latch.
REQ-017 tau_ack while tau_valid=0 SHALL be ignored.
REQ-018 Overrun: the first accept with hop_count==HOP while state is ARM, RUN or REPORT SHALL increment overrun_count once per launch; the count saturates at 16'hFFFF.
REQ-019 enable=0 SHALL only block IDLE->LAUNCH; an in-flight frame completes normally.
REQ-020 A core_ready pulse outside RUN SHALL be ignored.
REQ-021 Minimum launch latency SHALL be: accept completing the conditions at cycle n -> LAUNCH at n+1 -> core_rst low from n+3.

Reset
REQ-022 While reset=0 at a clk edge: state IDLE, fill_count 0, hop_count 0, frame_data 0, tau 0, tau_valid 0, timeout 0, busy 0, overrun_count 0, core_rst 1, s_ready 0; live buffer contents unspecified.
REQ-023 Reset asserted mid-RUN or mid-REPORT SHALL abort with no result; a refill of FRAME_LEN samples is required before the next launch.

Verification (WINDOW_SIZE_BITS=3, MAX_TAU=4, FRAME_LEN=12, HOP=4, TIMEOUT=20)
REQ-024 Stream samples 1..12 back-to-back, enable=1 -> LAUNCH the cycle after sample 12; frame_data index 0=1, index 11=12; core_rst 1 for exactly 2 cycles (LAUNCH, ARM) after IDLE.
REQ-025 Core returns core_ready=1, core_tau=7 in the 5th RUN cycle -> tau=7, tau_valid=1, timeout=0; tau_ack -> IDLE next cycle; 4 further samples -> second launch with index 0=5, index 11=16.
REQ-026 core_ready held 0 -> after 20 RUN cycles tau=0, timeout=1, tau_valid=1.
REQ-027 tau_ack withheld while 9 samples stream -> overrun_count=1, not 2; after ack, immediate relaunch from IDLE.
REQ-028 Reset pulsed in RUN -> all outputs at reset values next cycle; 11 samples give no launch, the 12th launches.
REQ-029 enable=0 with full buffer -> no launch; enable=1 -> LAUNCH the next cycle; a sample accepted in the LAUNCH cycle is excluded from the snapshot and leaves hop_count=1.
